// File: rtl/dm_dmi_responder_pkg.sv
// rtl/dm_dmi_responder_pkg.sv - shared DMI types, register map, cmderr codes and command FSM states
// Holds the DMI request/response structs, op codes, the register addresses
// decoded by the debug module, abstract-command error codes, the command FSM
// state enum and the constant dmstatus encoding.
package dm_dmi_responder_pkg;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_rsp_t;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RSP_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_RSP_FAILED  = 2'd2;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    typedef enum logic {
        CMD_IDLE = 1'b0,
        CMD_XFER = 1'b1
    } cmd_state_e;

    // version 2, authenticated, any/all halted or any/all running from one hart
    function automatic logic [31:0] dmstatus_value(input logic halted);
        return {20'b0, ~halted, ~halted, halted, halted, 1'b1, 3'b0, 4'd2};
    endfunction

endpackage

// File: rtl/dm_abstract_cmd.sv
// rtl/dm_abstract_cmd.sv - abstract command decode, cmderr tracking and GPR transfer FSM
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   active_i              dmactive as it will be after this edge; 0 clears everything
//   cmd_we_i, cmd_*_i     accepted write to command and its decoded fields
//   acs_we_i, acs_clr_i   accepted write to abstractcs and its cmderr W1C bits
//   busy_wr_i             accepted write to command, data0 or abstractcs
//   hart_halted_i         hart status
//   hart_reg_ack_i        single-cycle completion from the hart
//   busy_o, cmderr_o      abstractcs status fields
//   data0_load_o          capture hart_reg_rdata into data0 this edge
//   hart_reg_req_o/we_o/addr_o  GPR access port
module dm_abstract_cmd
    import dm_dmi_responder_pkg::*;
#(
    parameter int NGPR = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        active_i,
    input  logic        cmd_we_i,
    input  logic [7:0]  cmd_type_i,
    input  logic [2:0]  cmd_size_i,
    input  logic        cmd_transfer_i,
    input  logic        cmd_write_i,
    input  logic [15:0] cmd_regno_i,
    input  logic        acs_we_i,
    input  logic [2:0]  acs_clr_i,
    input  logic        busy_wr_i,
    input  logic        hart_halted_i,
    input  logic        hart_reg_ack_i,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic        data0_load_o,
    output logic        hart_reg_req_o,
    output logic        hart_reg_we_o,
    output logic [4:0]  hart_reg_addr_o
);

    localparam logic [16:0] REGNO_BASE = 17'h01000;
    localparam logic [16:0] REGNO_END  = 17'h01000 + 17'(NGPR);

    cmd_state_e  state_q, state_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic        regno_ok;
    logic [2:0]  decode_err;

    assign regno_ok = ({1'b0, cmd_regno_i} >= REGNO_BASE) && ({1'b0, cmd_regno_i} < REGNO_END);

    // Checks are ordered so that an unsupported command reports NOTSUP even
    // when the hart is running.
    always_comb begin
        decode_err = CMDERR_NONE;
        if (cmd_type_i != 8'd0) begin
            decode_err = CMDERR_NOTSUP;
        end else if (cmd_size_i != 3'd2) begin
            decode_err = CMDERR_NOTSUP;
        end else if (cmd_transfer_i && !regno_ok) begin
            decode_err = CMDERR_NOTSUP;
        end else if (!hart_halted_i) begin
            decode_err = CMDERR_HALTRESUME;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmderr_d     = cmderr_q;
        we_d         = we_q;
        addr_d       = addr_q;
        data0_load_o = 1'b0;
        if (!active_i) begin
            state_d  = CMD_IDLE;
            cmderr_d = CMDERR_NONE;
            we_d     = 1'b0;
            addr_d   = '0;
        end else if (state_q == CMD_XFER) begin
            // Interfering writes are dropped by the top; only flag them here.
            if (busy_wr_i && (cmderr_q == CMDERR_NONE)) begin
                cmderr_d = CMDERR_BUSY;
            end
            if (hart_reg_ack_i) begin
                state_d      = CMD_IDLE;
                data0_load_o = ~we_q;
            end
        end else begin
            if (acs_we_i) begin
                cmderr_d = cmderr_q & ~acs_clr_i;
            end
            // A pending error blocks every new command until software clears it.
            if (cmd_we_i && (cmderr_q == CMDERR_NONE)) begin
                if (decode_err != CMDERR_NONE) begin
                    cmderr_d = decode_err;
                end else if (cmd_transfer_i) begin
                    state_d = CMD_XFER;
                    we_d    = cmd_write_i;
                    addr_d  = cmd_regno_i[4:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CMD_IDLE;
            cmderr_q <= CMDERR_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmderr_q <= cmderr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
        end
    end

    assign busy_o          = (state_q == CMD_XFER);
    assign cmderr_o        = cmderr_q;
    assign hart_reg_req_o  = busy_o;
    assign hart_reg_we_o   = busy_o & we_q;
    assign hart_reg_addr_o = busy_o ? addr_q : 5'd0;

endmodule

// File: rtl/dm_dmi_responder.sv
// rtl/dm_dmi_responder.sv - debug module DMI responder with dmcontrol/dmstatus/abstractcs/data0
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   dmi_req/_valid/_ready          one request at a time from the DTM
//   dmi_rsp/_valid/_ready          response, held until consumed
//   halt_req, resume_req           hart run control (level, one-cycle pulse)
//   hart_halted                    hart status
//   hart_reg_*                     GPR access port driven by the abstract command engine
module dm_dmi_responder
    import dm_dmi_responder_pkg::*;
#(
    parameter int NGPR = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  dmi_t        dmi_req,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    output dmi_rsp_t    dmi_rsp,
    output logic        dmi_rsp_valid,
    input  logic        dmi_rsp_ready,
    output logic        halt_req,
    output logic        resume_req,
    input  logic        hart_halted,
    output logic        hart_reg_req,
    output logic        hart_reg_we,
    output logic [4:0]  hart_reg_addr,
    output logic [31:0] hart_reg_wdata,
    input  logic [31:0] hart_reg_rdata,
    input  logic        hart_reg_ack
);

    logic        init_q;
    logic        dmactive_q, dmactive_d;
    logic        haltreq_q, haltreq_d;
    logic        resume_q, resume_d;
    logic [31:0] data0_q, data0_d;
    logic        rsp_valid_q, rsp_valid_d;
    dmi_rsp_t    rsp_q, rsp_d;

    logic        accept, is_write;
    logic        wr_ctl, wr_data0, wr_acs, wr_cmd;
    logic [31:0] rdata;
    logic        busy, data0_load;
    logic [2:0]  cmderr;

    // init_q keeps ready low for the first cycle out of reset.
    assign dmi_req_ready = init_q & ~rsp_valid_q;
    assign accept        = dmi_req_valid & dmi_req_ready;
    assign is_write      = accept && (dmi_req.op == DMI_OP_WRITE);
    assign wr_ctl        = is_write && (dmi_req.addr == ADDR_DMCONTROL);
    assign wr_data0      = is_write && dmactive_q && (dmi_req.addr == ADDR_DATA0);
    assign wr_acs        = is_write && dmactive_q && (dmi_req.addr == ADDR_ABSTRACTCS);
    assign wr_cmd        = is_write && dmactive_q && (dmi_req.addr == ADDR_COMMAND);

    // Reads see the register state from before the accepting edge.
    always_comb begin
        rdata = 32'd0;
        case (dmi_req.addr)
            ADDR_DATA0:      rdata = data0_q;
            ADDR_DMCONTROL:  rdata = {haltreq_q, 30'b0, dmactive_q};
            ADDR_DMSTATUS:   rdata = dmstatus_value(hart_halted);
            ADDR_HARTINFO:   rdata = 32'd0;
            ADDR_ABSTRACTCS: rdata = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr, 4'b0, 4'd1};
            ADDR_COMMAND:    rdata = 32'd0;
            default:         rdata = 32'd0;
        endcase
    end

    always_comb begin
        dmactive_d  = dmactive_q;
        haltreq_d   = haltreq_q;
        resume_d    = 1'b0;
        data0_d     = data0_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        // dmcontrol takes its own dmactive bit into account, so activating and
        // halting in one write works.
        if (wr_ctl) begin
            dmactive_d = dmi_req.data[0];
            haltreq_d  = dmi_req.data[0] & dmi_req.data[31];
            resume_d   = dmi_req.data[0] & dmi_req.data[30] & ~dmi_req.data[31];
        end

        if (!dmactive_d) begin
            data0_d = 32'd0;
        end else if (data0_load) begin
            data0_d = hart_reg_rdata;
        end else if (wr_data0 && !busy) begin
            data0_d = dmi_req.data;
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            case (dmi_req.op)
                DMI_OP_READ:              rsp_d = '{data: rdata, op: DMI_RSP_SUCCESS};
                DMI_OP_NOP, DMI_OP_WRITE: rsp_d = '{data: 32'd0, op: DMI_RSP_SUCCESS};
                default:                  rsp_d = '{data: 32'd0, op: DMI_RSP_FAILED};
            endcase
        end else if (dmi_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q      <= 1'b0;
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            resume_q    <= 1'b0;
            data0_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            init_q      <= 1'b1;
            dmactive_q  <= dmactive_d;
            haltreq_q   <= haltreq_d;
            resume_q    <= resume_d;
            data0_q     <= data0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    dm_abstract_cmd #(
        .NGPR(NGPR)
    ) u_abstract_cmd (
        .clk_i           (clk),
        .rst_i           (rst),
        .active_i        (dmactive_d),
        .cmd_we_i        (wr_cmd),
        .cmd_type_i      (dmi_req.data[31:24]),
        .cmd_size_i      (dmi_req.data[22:20]),
        .cmd_transfer_i  (dmi_req.data[17]),
        .cmd_write_i     (dmi_req.data[16]),
        .cmd_regno_i     (dmi_req.data[15:0]),
        .acs_we_i        (wr_acs),
        .acs_clr_i       (dmi_req.data[10:8]),
        .busy_wr_i       (wr_cmd | wr_data0 | wr_acs),
        .hart_halted_i   (hart_halted),
        .hart_reg_ack_i  (hart_reg_ack),
        .busy_o          (busy),
        .cmderr_o        (cmderr),
        .data0_load_o    (data0_load),
        .hart_reg_req_o  (hart_reg_req),
        .hart_reg_we_o   (hart_reg_we),
        .hart_reg_addr_o (hart_reg_addr)
    );

    assign hart_reg_wdata = data0_q;
    assign halt_req       = haltreq_q;
    assign resume_req     = resume_q;
    assign dmi_rsp        = rsp_q;
    assign dmi_rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// tb/tb_dm_dmi_responder.sv - directed plus randomized self-checking bench for dm_dmi_responder
module tb_dm_dmi_responder;
    import dm_dmi_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    dmi_t        dmi_req;
    logic        dmi_req_valid, dmi_req_ready;
    dmi_rsp_t    dmi_rsp;
    logic        dmi_rsp_valid, dmi_rsp_ready;
    logic        halt_req, resume_req, hart_halted;
    logic        hart_reg_req, hart_reg_we, hart_reg_ack;
    logic [4:0]  hart_reg_addr;
    logic [31:0] hart_reg_wdata, hart_reg_rdata;

    int checks = 0;
    int errors = 0;
    int resume_cnt = 0;
    int req_rise = 0;
    logic req_prev = 1'b0;

    logic        snap_resume, snap_req, snap_we;
    logic [4:0]  snap_addr;
    logic [31:0] snap_wdata;

    logic [31:0] m_data0;
    logic [2:0]  m_cmderr;
    logic        m_halted;

    dm_dmi_responder #(.NGPR(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmi_req        (dmi_req),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_rsp        (dmi_rsp),
        .dmi_rsp_valid  (dmi_rsp_valid),
        .dmi_rsp_ready  (dmi_rsp_ready),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .hart_halted    (hart_halted),
        .hart_reg_req   (hart_reg_req),
        .hart_reg_we    (hart_reg_we),
        .hart_reg_addr  (hart_reg_addr),
        .hart_reg_wdata (hart_reg_wdata),
        .hart_reg_rdata (hart_reg_rdata),
        .hart_reg_ack   (hart_reg_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resume_req === 1'b1) resume_cnt <= resume_cnt + 1;
        if (hart_reg_req === 1'b1 && req_prev !== 1'b1) req_rise <= req_rise + 1;
        req_prev <= hart_reg_req;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] classify(input logic [31:0] cmd, input logic halted);
        int regno;
        regno = int'(cmd[15:0]);
        if (cmd[31:24] != 8'd0) return 3'd2;
        if (cmd[22:20] != 3'd2) return 3'd2;
        if (cmd[17] && (regno < 4096 || regno >= 4096 + 32)) return 3'd2;
        if (!halted) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [31:0] acs_exp(input logic [2:0] e);
        return 32'd1 + (32'(e) << 8);
    endfunction

    task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic [1:0] rop);
        int n;
        n = 0;
        dmi_req.addr  = addr;
        dmi_req.data  = data;
        dmi_req.op    = op;
        dmi_req_valid = 1'b1;
        while (dmi_req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("req_ready", dmi_req_ready, 1);
        step();
        dmi_req_valid = 1'b0;
        snap_resume = resume_req;
        snap_req    = hart_reg_req;
        snap_we     = hart_reg_we;
        snap_addr   = hart_reg_addr;
        snap_wdata  = hart_reg_wdata;
        check("rsp_valid_n1", dmi_rsp_valid, 1);
        rdata = dmi_rsp.data;
        rop   = dmi_rsp.op;
        step();
        check("rsp_hold", {dmi_rsp_valid, dmi_rsp}, {1'b1, rdata, rop});
        dmi_rsp_ready = 1'b1;
        step();
        dmi_rsp_ready = 1'b0;
    endtask

    task automatic dmi_wr(input logic [6:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic [1:0]  rop;
        dmi_xfer(DMI_OP_WRITE, addr, data, rd, rop);
        check("wr_op", rop, 0);
    endtask

    task automatic dmi_rd_check(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [1:0]  rop;
        dmi_xfer(DMI_OP_READ, addr, 32'd0, rd, rop);
        check(tag, {rop, rd}, {2'd0, exp});
    endtask

    task automatic hart_serve(input int dly, input logic [31:0] rd, input logic exp_we,
                              input logic [4:0] exp_addr, input logic [31:0] exp_wdata);
        int n;
        n = 0;
        while (hart_reg_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("hart_req", hart_reg_req, 1);
        check("hart_we", hart_reg_we, exp_we);
        check("hart_addr", hart_reg_addr, exp_addr);
        check("hart_wdata", hart_reg_wdata, exp_wdata);
        for (int i = 0; i < dly; i++) begin
            step();
            check("hart_req_held", hart_reg_req, 1);
        end
        hart_reg_ack   = 1'b1;
        hart_reg_rdata = rd;
        step();
        hart_reg_ack   = 1'b0;
        hart_reg_rdata = $urandom;
        check("hart_req_drop", hart_reg_req, 0);
    endtask

    initial begin
        int          r0, k;
        logic [31:0] v, cmd, rd;
        logic [2:0]  e;
        logic [1:0]  rop;

        rst = 1'b1;
        dmi_req = '0;
        dmi_req_valid = 1'b0;
        dmi_rsp_ready = 1'b0;
        hart_halted = 1'b0;
        hart_reg_ack = 1'b0;
        hart_reg_rdata = 32'd0;
        repeat (3) step();
        check("rst_outputs", {halt_req, resume_req, hart_reg_req, hart_reg_we, dmi_rsp_valid, dmi_req_ready}, 0);
        check("rst_rsp", dmi_rsp, 0);
        rst = 1'b0;
        check("ready_pre", dmi_req_ready, 0);
        step();
        check("ready_post", dmi_req_ready, 1);

        dmi_rd_check("dmstatus_run", ADDR_DMSTATUS, 32'h0000_0C82);

        dmi_wr(ADDR_DMCONTROL, 32'h8000_0001);
        check("halt_set", halt_req, 1);
        check("no_resume", resume_cnt, 0);
        dmi_wr(ADDR_DMCONTROL, 32'h4000_0001);
        check("resume_n1", snap_resume, 1);
        check("resume_cnt", resume_cnt, 1);
        check("halt_clr", halt_req, 0);
        dmi_wr(ADDR_DMCONTROL, 32'hC000_0001);
        check("resume_suppr", resume_cnt, 1);
        check("halt_again", halt_req, 1);
        dmi_wr(ADDR_DMCONTROL, 32'h0000_0001);
        check("halt_off", halt_req, 0);

        hart_halted = 1'b1;
        dmi_rd_check("dmstatus_halt", ADDR_DMSTATUS, 32'h0000_0382);
        dmi_wr(ADDR_DATA0, 32'hDEAD_BEEF);
        dmi_wr(ADDR_COMMAND, 32'h0023_1005);
        check("wr_req_n1", {snap_req, snap_we, snap_addr, snap_wdata}, {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF});
        hart_serve(3, $urandom, 1'b1, 5'd5, 32'hDEAD_BEEF);
        dmi_rd_check("acs_done", ADDR_ABSTRACTCS, 32'h0000_0001);
        dmi_rd_check("data0_kept", ADDR_DATA0, 32'hDEAD_BEEF);

        dmi_wr(ADDR_COMMAND, 32'h0022_1003);
        hart_serve(1, 32'h1234_5678, 1'b0, 5'd3, 32'hDEAD_BEEF);
        dmi_rd_check("data0_read", ADDR_DATA0, 32'h1234_5678);

        dmi_wr(ADDR_COMMAND, 32'h0022_1003);
        check("busy_req_n1", snap_req, 1);
        dmi_wr(ADDR_COMMAND, 32'h0022_1003);
        dmi_rd_check("acs_busyerr", ADDR_ABSTRACTCS, 32'h0000_1101);
        dmi_rd_check("data0_stale", ADDR_DATA0, 32'h1234_5678);
        dmi_wr(ADDR_DATA0, 32'hFFFF_FFFF);
        hart_serve(0, 32'hA5A5_0001, 1'b0, 5'd3, 32'h1234_5678);
        dmi_rd_check("acs_err_idle", ADDR_ABSTRACTCS, 32'h0000_0101);
        dmi_rd_check("data0_ack", ADDR_DATA0, 32'hA5A5_0001);
        dmi_wr(ADDR_ABSTRACTCS, 32'h0000_0700);
        dmi_rd_check("acs_cleared", ADDR_ABSTRACTCS, 32'h0000_0001);

        hart_halted = 1'b0;
        r0 = req_rise;
        dmi_wr(ADDR_COMMAND, 32'h0022_1003);
        check("nohalt_req", snap_req, 0);
        dmi_rd_check("acs_haltresume", ADDR_ABSTRACTCS, 32'h0000_0401);
        check("nohalt_rise", req_rise, r0);
        dmi_wr(ADDR_ABSTRACTCS, 32'h0000_0700);
        dmi_wr(ADDR_COMMAND, 32'h0100_0000);
        dmi_rd_check("acs_notsup", ADDR_ABSTRACTCS, 32'h0000_0201);
        dmi_wr(ADDR_ABSTRACTCS, 32'h0000_0700);
        dmi_rd_check("acs_clr2", ADDR_ABSTRACTCS, 32'h0000_0001);

        dmi_xfer(2'd3, ADDR_DATA0, 32'd0, rd, rop);
        check("op3_failed", rop, 2);
        dmi_rd_check("unmapped_rd", 7'h30, 32'd0);
        dmi_wr(7'h30, 32'h5555_5555);
        dmi_rd_check("hartinfo", ADDR_HARTINFO, 32'd0);

        m_data0  = 32'hA5A5_0001;
        m_cmderr = 3'd0;
        m_halted = 1'b0;
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: begin
                    v = $urandom;
                    dmi_wr(ADDR_DATA0, v);
                    m_data0 = v;
                end
                1: begin
                    cmd = 32'd0;
                    cmd[31:24] = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
                    cmd[22:20] = ($urandom_range(0, 5) == 0) ? 3'd3 : 3'd2;
                    cmd[17]    = ($urandom_range(0, 4) != 0);
                    cmd[16]    = 1'($urandom_range(0, 1));
                    cmd[15:0]  = 16'(4095 + $urandom_range(0, 34));
                    e = classify(cmd, m_halted);
                    dmi_wr(ADDR_COMMAND, cmd);
                    if (m_cmderr != 3'd0) begin
                        check("rnd_blocked", snap_req, 0);
                    end else if (e != 3'd0) begin
                        m_cmderr = e;
                        check("rnd_err_noreq", snap_req, 0);
                    end else if (cmd[17]) begin
                        check("rnd_req_n1", snap_req, 1);
                        rd = $urandom;
                        hart_serve($urandom_range(0, 4), rd, cmd[16], cmd[4:0], m_data0);
                        if (!cmd[16]) m_data0 = rd;
                    end else begin
                        check("rnd_notransfer", snap_req, 0);
                    end
                end
                2: begin
                    v = 32'($urandom_range(0, 7)) << 8;
                    dmi_wr(ADDR_ABSTRACTCS, v);
                    m_cmderr = m_cmderr & ~v[10:8];
                end
                3: begin
                    m_halted = !m_halted;
                    hart_halted = m_halted;
                end
                default: begin
                    dmi_rd_check("rnd_dmstatus", ADDR_DMSTATUS,
                                 32'h82 + (m_halted ? 32'h300 : 32'hC00));
                end
            endcase
            dmi_rd_check("rnd_data0", ADDR_DATA0, m_data0);
            dmi_rd_check("rnd_acs", ADDR_ABSTRACTCS, acs_exp(m_cmderr));
        end

        dmi_wr(ADDR_DMCONTROL, 32'h0000_0000);
        dmi_rd_check("inactive_data0", ADDR_DATA0, 32'd0);
        dmi_wr(ADDR_DATA0, 32'h0000_1234);
        dmi_rd_check("inactive_wr_ign", ADDR_DATA0, 32'd0);
        dmi_rd_check("inactive_ctl", ADDR_DMCONTROL, 32'd0);
        dmi_wr(ADDR_DMCONTROL, 32'h0000_0001);
        dmi_rd_check("active_ctl", ADDR_DMCONTROL, 32'd1);

        hart_halted = 1'b1;
        dmi_wr(ADDR_DATA0, 32'h0BAD_F00D);
        dmi_wr(ADDR_COMMAND, 32'h0022_1007);
        check("pre_rst_req", hart_reg_req, 1);
        rst = 1'b1;
        step();
        check("rst_drop_req", hart_reg_req, 0);
        step();
        rst = 1'b0;
        hart_reg_ack = 1'b1;
        hart_reg_rdata = 32'hFFFF_0000;
        step();
        hart_reg_ack = 1'b0;
        dmi_wr(ADDR_DMCONTROL, 32'h0000_0001);
        dmi_rd_check("late_ack_data0", ADDR_DATA0, 32'd0);
        dmi_rd_check("late_ack_acs", ADDR_ABSTRACTCS, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_dmi_responder.md
# dm_dmi_responder

Debug Module side of the DMI link: accepts `dmi_t` requests issued by `dtm`, decodes them against a minimal RISC-V Debug Spec 0.13 register set, and returns `dmi_rsp_t` responses. It holds `dmcontrol`, `dmstatus`, `hartinfo`, `abstractcs`, `command` and `data0`, and drives halt/resume requests to one hart. It also runs an abstract-command engine for GPR access through a simple request/ack port into the hart.

## Interface
Parameters:
- `NGPR`, 32: number of hart GPRs reachable via abstract access register.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `dmi_req`  in  `dmi_t`  request: `addr[6:0]`, `data[31:0]`, `op[1:0]` (0 nop, 1 read, 2 write).
- `dmi_req_valid`  in  1  request present.
- `dmi_req_ready`  out  1  request accepted when valid&ready.
- `dmi_rsp`  out  `dmi_rsp_t`  response: `data[31:0]`, `op[1:0]` (0 success, 2 failed).
- `dmi_rsp_valid`  out  1  response present.
- `dmi_rsp_ready`  in  1  response consumed when valid&ready.
- `halt_req`  out  1  level, mirrors `dmcontrol.haltreq`.
- `resume_req`  out  1  one-cycle pulse when `resumereq` is written 1.
- `hart_halted`  in  1  hart status.
- `hart_reg_req`  out  1  GPR access request; held until ack.
- `hart_reg_we`  out  1  write when 1.
- `hart_reg_addr`  out  5  GPR index.
- `hart_reg_wdata`  out  32  write data (`data0`).
- `hart_reg_rdata`  in  32  read data, valid with ack.
- `hart_reg_ack`  in  1  single-cycle completion.

## Operation
- At most one outstanding transaction. `dmi_req_ready = !dmi_rsp_valid`.
- Register map:
  - 0x04 `data0`, RW.
  - 0x10 `dmcontrol`: bit0 `dmactive`, bit30 `resumereq`, bit31 `haltreq`.
  - 0x11 `dmstatus`, RO: `[3:0]`=2, bit7 authenticated=1, bit8/9 any/allhalted = `hart_halted`, bit10/11 any/allrunning = `!hart_halted`.
  - 0x12 `hartinfo`, RO 0.
  - 0x16 `abstractcs`: `[3:0]` datacount=1, `[10:8]` cmderr (W1C), bit12 busy, `[28:24]` progbufsize=0.
  - 0x17 `command`, WO, reads 0.
- Unmapped read returns 0 with op 0. Unmapped write is ignored with op 0. `op`=3 returns op 2 (failed).
- While `dmactive`=0, every register except `dmactive` is held at reset value and writes to other registers are ignored. Clearing `dmactive` aborts any running command.
- Command decode (cmdtype `[31:24]`):
  - Non-zero cmdtype → cmderr=2.
  - `aarsize[22:20]`≠2 → cmderr=2.
  - `transfer[17]`=1 with `regno[15:0]` outside 0x1000..0x1000+NGPR-1 → cmderr=2.
  - `!hart_halted` → cmderr=4.
  - `transfer[17]`=0 → completes with no hart access.
  - A command is dropped whenever cmderr≠0 beforehand.
- While busy, a write to `command`, `data0` or `abstractcs` sets cmderr=1 if cmderr=0, and the write itself is dropped. A `data0` read while busy returns the stale value.
- Command FSM:
  - IDLE → XFER on an accepted legal command with transfer=1.
  - XFER holds `hart_reg_req`, `hart_reg_we`=`write[16]`, `hart_reg_addr`=`regno[4:0]`.
  - On `hart_reg_ack`: a read latches `hart_reg_rdata` into `data0`, then → IDLE.
- DMI response for any write, including an illegal command, is op 0. Errors are reported only through cmderr.

## Timing
- Reset values: all outputs 0, all registers 0, FSM IDLE. `dmi_req_ready`=1 one cycle after reset deasserts.
- Request accepted at edge N → `dmi_rsp_valid`=1 at N+1, held stable until `dmi_rsp_ready`.
- Read data is sampled at edge N.
- busy=1 and `hart_reg_req`=1 from N+1 after a command write.
- Ack at edge M → `hart_reg_req`=0, busy=0 and `data0` updated at M+1.
- A DMI read of `abstractcs` accepted at edge M sees busy=1.
- `resume_req` is high for exactly cycle N+1. It is suppressed if `haltreq` is written 1 in the same write.
- `rst` mid-transfer drops `hart_reg_req` at the next edge. A late ack is ignored.
- Ack and a DMI request on the same edge are both processed. The request sees pre-ack state.

## Structure
- `dmi_t`, `dmi_rsp_t`, DMI op codes, register addresses, cmderr codes and FSM state enum all go in `debug.vh`, shared with `dtm`.
- One natural sub-module: `dm_abstract_cmd` (command decode, cmderr generation, XFER FSM, hart port). The DMI register decode stays in the top module.

## Test plan
- Reset, read 0x11 with `hart_halted`=0 → data 0x00000C82, op 0; rsp_valid one cycle after accept.
- Write 0x10=0x80000001 → `halt_req`=1. Then write 0x40000001 → `resume_req` pulses one cycle and `halt_req`=0.
- Halted; write data0=0xDEADBEEF, command=0x00231005 → `hart_reg_req`/`we`=1, addr 5, wdata 0xDEADBEEF. Ack after 3 cycles → 0x16 reads 0x00000001.
- Halted; command=0x00221003, hart returns 0x12345678 on ack → data0 reads 0x12345678.
- Command while busy → cmderr=1 (0x16 reads 0x1101). Write 0x16=0x700 → cmderr cleared.
- Not halted, command=0x00221003 → cmderr=4, no `hart_reg_req`. Command=0x01000000 after clearing → cmderr=2.
